// File: rtl/mips_exc_pkg.sv
// Shared types and constants for the MIPS exception sequencer: FSM states,
// ExcCode values and the 12-bit handler vector offsets.
package mips_exc_pkg;

  localparam int CAUSE_W = 5;
  localparam int VEC_W   = 12;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_HANDLER  = 2'd2,
    ST_RETURN   = 2'd3
  } exc_state_t;

  localparam logic [CAUSE_W-1:0] EXC_INT = 5'd0;
  localparam logic [CAUSE_W-1:0] EXC_RI  = 5'd10;
  localparam logic [CAUSE_W-1:0] EXC_OV  = 5'd12;

  localparam logic [VEC_W-1:0] VEC_RI  = 12'h3F0;
  localparam logic [VEC_W-1:0] VEC_OV  = 12'h3F8;
  localparam logic [VEC_W-1:0] VEC_INT = 12'h3E8;
  localparam logic [VEC_W-1:0] VEC_DF  = 12'h3E0;

endpackage

// File: rtl/mips_exception_sequencer_if.sv
// Bundle between the core datapath (master) and the exception sequencer (slave).
// Flags are qualified by instr_valid; pc_load is a one-cycle strobe with no back-pressure.
interface mips_exception_sequencer_if
  import mips_exc_pkg::*;
#(
  parameter int WSIZE = 32
);

  logic               instr_valid;
  logic [WSIZE-1:0]   pc_in;
  logic               overflow;
  logic               unknown_opcode;
  logic               irq;
  logic               eret;

  logic               pc_load;
  logic [WSIZE-1:0]   pc_load_addr;
  logic               flush;
  logic [WSIZE-1:0]   epc;
  logic [CAUSE_W-1:0] cause;
  logic               exl;
  logic               double_fault;

  modport master (
    output instr_valid, pc_in, overflow, unknown_opcode, irq, eret,
    input  pc_load, pc_load_addr, flush, epc, cause, exl, double_fault
  );

  modport slave (
    input  instr_valid, pc_in, overflow, unknown_opcode, irq, eret,
    output pc_load, pc_load_addr, flush, epc, cause, exl, double_fault
  );

endinterface

// File: rtl/mips_exc_prio_enc.sv
// Combinational exception priority encoder: unknown_opcode > overflow > irq.
// Produces {valid, ExcCode, 12-bit vector offset}.
module mips_exc_prio_enc
  import mips_exc_pkg::*;
(
  input  logic               unknown_opcode,
  input  logic               overflow,
  input  logic               irq,
  output logic               valid,
  output logic [CAUSE_W-1:0] code,
  output logic [VEC_W-1:0]   vec
);

  always_comb begin
    valid = 1'b0;
    code  = EXC_INT;
    vec   = VEC_INT;
    if (unknown_opcode) begin
      valid = 1'b1;
      code  = EXC_RI;
      vec   = VEC_RI;
    end else if (overflow) begin
      valid = 1'b1;
      code  = EXC_OV;
      vec   = VEC_OV;
    end else if (irq) begin
      valid = 1'b1;
      code  = EXC_INT;
      vec   = VEC_INT;
    end
  end

endmodule

// File: rtl/mips_exception_sequencer.sv
// Sequential exception controller: flush, one-cycle redirect to the handler vector,
// EXL hold until eret, then redirect back to EPC. External irq enabled by MIPS_EXC_IRQ_EN.
module mips_exception_sequencer
  import mips_exc_pkg::*;
#(
  parameter int WSIZE = 32
)(
  input  logic                         clk,
  input  logic                         rst_n,
  mips_exception_sequencer_if.slave    bus,
  output exc_state_t                   dbg_state
);

`ifdef MIPS_EXC_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  exc_state_t         state_q, state_d;
  logic [WSIZE-1:0]   epc_q, epc_d;
  logic [WSIZE-1:0]   addr_q, addr_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic               df_q, df_d;
  logic               flush_c;

  logic               irq_live;
  logic               exc_valid;
  logic [CAUSE_W-1:0] exc_code;
  logic [VEC_W-1:0]   exc_vec;
  logic               take_exc;

  // irq is only honoured outside exception level; in HANDLER it is masked.
  assign irq_live = bus.irq & IRQ_EN & (state_q == ST_IDLE);

  mips_exc_prio_enc u_prio_enc (
    .unknown_opcode (bus.unknown_opcode),
    .overflow       (bus.overflow),
    .irq            (irq_live),
    .valid          (exc_valid),
    .code           (exc_code),
    .vec            (exc_vec)
  );

  assign take_exc = bus.instr_valid & exc_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      epc_q   <= '0;
      addr_q  <= '0;
      cause_q <= '0;
      df_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      addr_q  <= addr_d;
      cause_q <= cause_d;
      df_q    <= df_d;
    end
  end

  // addr_q doubles as the redirect target; it is loaded on entry to REDIRECT/RETURN
  // so pc_load_addr stays held between strobes.
  always_comb begin
    state_d = state_q;
    epc_d   = epc_q;
    addr_d  = addr_q;
    cause_d = cause_q;
    df_d    = df_q;
    flush_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (take_exc) begin
          flush_c = 1'b1;
          epc_d   = bus.pc_in;
          cause_d = exc_code;
          addr_d  = WSIZE'(exc_vec);
          state_d = ST_REDIRECT;
        end
      end
      ST_REDIRECT: begin
        state_d = ST_HANDLER;
      end
      ST_HANDLER: begin
        // A fault inside the handler beats a coincident eret; EPC/Cause stay intact.
        if (take_exc) begin
          flush_c = 1'b1;
          df_d    = 1'b1;
          addr_d  = WSIZE'(VEC_DF);
          state_d = ST_REDIRECT;
        end else if (bus.instr_valid && bus.eret) begin
          addr_d  = epc_q;
          state_d = ST_RETURN;
        end
      end
      ST_RETURN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.pc_load      = (state_q == ST_REDIRECT) || (state_q == ST_RETURN);
  assign bus.pc_load_addr = addr_q;
  assign bus.flush        = flush_c;
  assign bus.epc          = epc_q;
  assign bus.cause        = cause_q;
  assign bus.exl          = (state_q == ST_REDIRECT) || (state_q == ST_HANDLER);
  assign bus.double_fault = df_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_mips_exception_sequencer.sv
// Directed self-checking bench for mips_exception_sequencer; irq expectations
// follow MIPS_EXC_IRQ_EN when it is defined for the build.
module tb_mips_exception_sequencer;
  import mips_exc_pkg::*;

  logic       clk;
  logic       rst_n;
  exc_state_t dbg_state;
  int         tests_run;
  int         tests_failed;

  mips_exception_sequencer_if #(.WSIZE(32)) bus ();

  mips_exception_sequencer #(.WSIZE(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] pc, input logic ov,
                        input logic ri, input logic iq, input logic er);
    bus.instr_valid    = v;
    bus.pc_in          = pc;
    bus.overflow       = ov;
    bus.unknown_opcode = ri;
    bus.irq            = iq;
    bus.eret           = er;
  endtask

  task automatic clear_in();
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    clear_in();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state",   32'(dbg_state),        32'(ST_IDLE));
    chk("rst_pc_load", 32'(bus.pc_load),      32'h0);
    chk("rst_addr",    bus.pc_load_addr,      32'h0);
    chk("rst_flush",   32'(bus.flush),        32'h0);
    chk("rst_epc",     bus.epc,               32'h0);
    chk("rst_cause",   32'(bus.cause),        32'h0);
    chk("rst_exl",     32'(bus.exl),          32'h0);
    chk("rst_df",      32'(bus.double_fault), 32'h0);
    rst_n = 1'b1;
    tick();

    // Overflow at 0x40
    set_in(1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("ov_flush_n",   32'(bus.flush),   32'h1);
    chk("ov_pcload_n",  32'(bus.pc_load), 32'h0);
    tick();
    clear_in();
    chk("ov_pcload_n1", 32'(bus.pc_load), 32'h1);
    chk("ov_addr",      bus.pc_load_addr, 32'h3F8);
    chk("ov_cause",     32'(bus.cause),   32'd12);
    chk("ov_epc",       bus.epc,          32'h40);
    chk("ov_exl",       32'(bus.exl),     32'h1);
    // flags in REDIRECT are ignored
    set_in(1'b1, 32'h3F8, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("redir_flush",  32'(bus.flush),   32'h0);
    tick();
    clear_in();
    chk("ov_handler",   32'(dbg_state),   32'(ST_HANDLER));
    chk("ov_pcload_n2", 32'(bus.pc_load), 32'h0);
    chk("ov_exl_n2",    32'(bus.exl),     32'h1);
    chk("ov_addr_held", bus.pc_load_addr, 32'h3F8);
    set_in(1'b1, 32'h3FC, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    clear_in();
    chk("ov_ret_pcload", 32'(bus.pc_load), 32'h1);
    chk("ov_ret_addr",   bus.pc_load_addr, 32'h40);
    chk("ov_ret_exl",    32'(bus.exl),     32'h0);
    tick();
    chk("ov_idle",       32'(dbg_state),   32'(ST_IDLE));
    chk("ov_idle_pcl",   32'(bus.pc_load), 32'h0);

    // Overflow + unknown opcode at 0x80: RI wins
    set_in(1'b1, 32'h80, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    clear_in();
    chk("both_addr",  bus.pc_load_addr, 32'h3F0);
    chk("both_cause", 32'(bus.cause),   32'd10);
    chk("both_epc",   bus.epc,          32'h80);
    tick();
    set_in(1'b1, 32'h3F0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    clear_in();
    tick();

    // Round trip: RI at 0x100, eret two cycles later
    set_in(1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    clear_in();
    tick();
    set_in(1'b1, 32'h3F0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    clear_in();
    chk("rt_pcload", 32'(bus.pc_load), 32'h1);
    chk("rt_addr",   bus.pc_load_addr, 32'h100);
    chk("rt_exl",    32'(bus.exl),     32'h0);
    tick();
    chk("rt_idle",   32'(dbg_state),   32'(ST_IDLE));

    // Double fault: overflow + eret in HANDLER with epc=0x100
    set_in(1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    clear_in();
    tick();
    set_in(1'b1, 32'h3F4, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    clear_in();
    chk("df_pcload", 32'(bus.pc_load),      32'h1);
    chk("df_addr",   bus.pc_load_addr,      32'h3E0);
    chk("df_flag",   32'(bus.double_fault), 32'h1);
    chk("df_epc",    bus.epc,               32'h100);
    chk("df_cause",  32'(bus.cause),        32'd10);
    chk("df_exl",    32'(bus.exl),          32'h1);
    tick();
    set_in(1'b1, 32'h3E0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    clear_in();
    chk("df_ret_addr", bus.pc_load_addr, 32'h100);
    tick();
    chk("df_sticky", 32'(bus.double_fault), 32'h1);

    // eret in IDLE is a NOP
    set_in(1'b1, 32'h140, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    chk("eret_idle_flush", 32'(bus.flush), 32'h0);
    tick();
    clear_in();
    chk("eret_idle_pcl",   32'(bus.pc_load), 32'h0);
    chk("eret_idle_state", 32'(dbg_state),   32'(ST_IDLE));

    // Flags without instr_valid are ignored
    set_in(1'b0, 32'h144, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    chk("novalid_flush", 32'(bus.flush), 32'h0);
    tick();
    clear_in();
    chk("novalid_pcl",   32'(bus.pc_load), 32'h0);

    // irq in IDLE at 0x200
    set_in(1'b1, 32'h200, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
`ifdef MIPS_EXC_IRQ_EN
    chk("irq_flush", 32'(bus.flush), 32'h1);
    tick();
    clear_in();
    chk("irq_pcload", 32'(bus.pc_load), 32'h1);
    chk("irq_addr",   bus.pc_load_addr, 32'h3E8);
    chk("irq_cause",  32'(bus.cause),   32'd0);
    chk("irq_epc",    bus.epc,          32'h200);
    tick();
`else
    chk("irq_flush", 32'(bus.flush), 32'h0);
    tick();
    clear_in();
    chk("irq_pcload", 32'(bus.pc_load), 32'h0);
    chk("irq_state",  32'(dbg_state),   32'(ST_IDLE));
    set_in(1'b1, 32'h300, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    clear_in();
    tick();
`endif
    // irq inside HANDLER is masked
    set_in(1'b1, 32'h3E8, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("hirq_flush", 32'(bus.flush), 32'h0);
    tick();
    clear_in();
    chk("hirq_pcload", 32'(bus.pc_load), 32'h0);
    chk("hirq_state",  32'(dbg_state),   32'(ST_HANDLER));
    set_in(1'b1, 32'h3EC, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    clear_in();
`ifdef MIPS_EXC_IRQ_EN
    chk("hirq_ret_addr", bus.pc_load_addr, 32'h200);
`else
    chk("hirq_ret_addr", bus.pc_load_addr, 32'h300);
`endif
    tick();

    // Asynchronous reset during REDIRECT
    set_in(1'b1, 32'h400, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    clear_in();
    chk("ar_pcload_pre", 32'(bus.pc_load), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("ar_pcload", 32'(bus.pc_load),      32'h0);
    chk("ar_addr",   bus.pc_load_addr,      32'h0);
    chk("ar_exl",    32'(bus.exl),          32'h0);
    chk("ar_epc",    bus.epc,               32'h0);
    chk("ar_cause",  32'(bus.cause),        32'h0);
    chk("ar_df",     32'(bus.double_fault), 32'h0);
    chk("ar_state",  32'(dbg_state),        32'(ST_IDLE));
    tick();
    rst_n = 1'b1;
    tick();
    chk("ar_post_pcload", 32'(bus.pc_load), 32'h0);
    chk("ar_post_exl",    32'(bus.exl),     32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
